// File: rtl/step_ctrl_pkg.sv
// Shared types and helpers for the counter step sequencer.
//   state_t      : sequencer states (IDLE / HOLD / REPEAT)
//   DIR_UP/DIR_DN: values driven on cnt_up for each direction
//   timer_width(): bits needed by the rate timer to hold max(HOLD_CYC, RPT_CYC) - 1
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int unsigned timer_width(input int unsigned hold_cyc,
                                              input int unsigned rpt_cyc);
    int unsigned m;
    m = (hold_cyc > rpt_cyc) ? hold_cyc : rpt_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/step_rate_timer.sv
// Loadable down-counter pacing the hold and auto-repeat intervals.
// Ports:
//   clk        : clock, rising edge
//   nrst       : asynchronous reset, active-low
//   load_i     : load load_val_i and start counting down
//   load_val_i : reload value (interval - 1)
//   clear_i    : stop and zero the timer (has priority over load_i)
//   expire_o   : high for the single cycle the running count sits at zero
module step_rate_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (load_i) begin
      cnt_d = load_val_i;
      run_d = 1'b1;
    end else if (run_q) begin
      // Park at zero once expired unless the owner reloads.
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/counter_step_ctrl.sv
// Step sequencer for the shared up/down counter. Grants the counter to one debounced button
// on a clean rising edge, issues a one-cycle step strobe, then auto-repeats while held.
// Optional feature macro: STEP_CTRL_SATURATE_EN (suppress steps past 0 / all-ones).
// Ports:
//   clk, nrst       : clock (rising edge), asynchronous active-low reset
//   btn_up, btn_dn  : debounced button levels, synchronous to clk
//   q               : current counter value, used for limit checks
//   cnt_en          : one-cycle step strobe to the counter
//   cnt_up          : step direction, 1 = up; holds while cnt_en is low
//   busy            : a button currently owns the counter
//   limit_hit       : one-cycle pulse when a step is suppressed at a limit
module counter_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned NBITS    = 4,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned RPT_CYC  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic [NBITS-1:0] q,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             limit_hit
);

  localparam int unsigned TW = timer_width(HOLD_CYC, RPT_CYC);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] RPT_LD  = TW'(RPT_CYC - 1);

  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   btn_up_q, btn_dn_q;
  logic   cnt_en_q, cnt_en_d;
  logic   cnt_up_q, cnt_up_d;
  logic   busy_q, busy_d;
  logic   limit_q, limit_d;

  logic          press_up, press_dn, held;
  logic          step, step_dir, at_limit;
  logic          tmr_load, tmr_clear, tmr_expire;
  logic [TW-1:0] tmr_val;

  assign press_up = btn_up & ~btn_up_q;
  assign press_dn = btn_dn & ~btn_dn_q;
  assign held     = (dir_q == DIR_UP) ? btn_up : btn_dn;

`ifdef STEP_CTRL_SATURATE_EN
  always_comb begin
    at_limit = (step_dir == DIR_UP) ? (q == {NBITS{1'b1}}) : (q == '0);
  end
`else
  logic unused_q;
  assign unused_q = ^q;
  always_comb begin
    at_limit = 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    step      = 1'b0;
    step_dir  = dir_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = HOLD_LD;
    unique case (state_q)
      IDLE: begin
        // The other button must be low: simultaneous or overlapping presses grant nothing.
        if (press_up && !btn_dn) begin
          step     = 1'b1;
          step_dir = DIR_UP;
          dir_d    = DIR_UP;
          state_d  = HOLD;
          tmr_load = 1'b1;
        end else if (press_dn && !btn_up) begin
          step     = 1'b1;
          step_dir = DIR_DN;
          dir_d    = DIR_DN;
          state_d  = HOLD;
          tmr_load = 1'b1;
        end
      end
      HOLD, REPEAT: begin
        // Release is checked first so it wins over a coincident expiry.
        if (!held) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
        end else if (tmr_expire) begin
          step     = 1'b1;
          state_d  = REPEAT;
          tmr_load = 1'b1;
          tmr_val  = RPT_LD;
        end
      end
      default: begin
        state_d   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    cnt_en_d = 1'b0;
    cnt_up_d = cnt_up_q;
    limit_d  = 1'b0;
    if (step) begin
      if (at_limit) begin
        limit_d = 1'b1;
      end else begin
        cnt_en_d = 1'b1;
        cnt_up_d = step_dir;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      dir_q    <= DIR_DN;
      btn_up_q <= 1'b0;
      btn_dn_q <= 1'b0;
      cnt_en_q <= 1'b0;
      cnt_up_q <= 1'b0;
      busy_q   <= 1'b0;
      limit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      btn_up_q <= btn_up;
      btn_dn_q <= btn_dn;
      cnt_en_q <= cnt_en_d;
      cnt_up_q <= cnt_up_d;
      busy_q   <= busy_d;
      limit_q  <= limit_d;
    end
  end

  step_rate_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .nrst       (nrst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .clear_i    (tmr_clear),
    .expire_o   (tmr_expire)
  );

  assign cnt_en    = cnt_en_q;
  assign cnt_up    = cnt_up_q;
  assign busy      = busy_q;
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl (NBITS=4, HOLD_CYC=8, RPT_CYC=4). Expected step events are queued
// by the stimulus; a negedge monitor pops and compares each strobe or limit pulse.
module tb_counter_step_ctrl;

  logic       clk;
  logic       nrst;
  logic       btn_up, btn_dn;
  logic [3:0] q;
  logic       cnt_en, cnt_up, busy, limit_hit;

  typedef struct {
    int cyc;
    bit up;
    bit lim;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t0;

  counter_step_ctrl #(
    .NBITS    (4),
    .HOLD_CYC (8),
    .RPT_CYC  (4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .q         (q),
    .cnt_en    (cnt_en),
    .cnt_up    (cnt_up),
    .busy      (busy),
    .limit_hit (limit_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue a step expected in cycle c; with saturation compiled in, a step at a limit
  // becomes a limit_hit pulse instead.
  task automatic expect_step(input int c, input bit up, input logic [3:0] qv);
    exp_t e;
    e.cyc = c;
    e.up  = up;
    e.lim = 1'b0;
`ifdef STEP_CTRL_SATURATE_EN
    e.lim = up ? (qv == 4'hF) : (qv == 4'h0);
`endif
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_step: expected event in cycle %0d, none by cycle %0d",
                 exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (cnt_en || limit_hit) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_step: cnt_en=%0b limit_hit=%0b in cycle %0d, none expected",
                   cnt_en, limit_hit, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("step_cycle", cyc, e.cyc);
          check("step_cnt_en", int'(cnt_en), int'(!e.lim));
          check("step_limit_hit", int'(limit_hit), int'(e.lim));
          if (!e.lim) check("step_cnt_up", int'(cnt_up), int'(e.up));
        end
      end
    end
  end

  initial begin
    nrst   = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    q      = 4'd5;
    tick(3);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_cnt_up", int'(cnt_up), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_limit_hit", int'(limit_hit), 0);
    nrst = 1'b1;
    tick(2);

    // Short Up press, 3 cycles, q=5.
    t0 = cyc;
    expect_step(t0 + 1, 1'b1, q);
    btn_up = 1'b1;
    tick(1);
    check("short_busy_on", int'(busy), 1);
    tick(2);
    btn_up = 1'b0;
    check("short_busy_held", int'(busy), 1);
    tick(1);
    check("short_busy_off", int'(busy), 0);
    tick(4);

    // Down held 20 cycles: steps at 1, 9, 13, 17.
    t0 = cyc;
    expect_step(t0 + 1, 1'b0, q);
    expect_step(t0 + 9, 1'b0, q);
    expect_step(t0 + 13, 1'b0, q);
    expect_step(t0 + 17, 1'b0, q);
    btn_dn = 1'b1;
    tick(20);
    btn_dn = 1'b0;
    check("dn_busy_before_rel", int'(busy), 1);
    tick(1);
    check("dn_busy_after_rel", int'(busy), 0);
    tick(6);

    // Both rise together, Up released, Down still held: no grant.
    btn_up = 1'b1;
    btn_dn = 1'b1;
    tick(2);
    check("both_busy", int'(busy), 0);
    btn_up = 1'b0;
    tick(3);
    check("both_dn_left_busy", int'(busy), 0);
    btn_dn = 1'b0;
    tick(3);
    check("both_busy_end", int'(busy), 0);

    // Up granted, Down pressed during HOLD is ignored.
    t0 = cyc;
    expect_step(t0 + 1, 1'b1, q);
    expect_step(t0 + 9, 1'b1, q);
    expect_step(t0 + 13, 1'b1, q);
    btn_up = 1'b1;
    tick(3);
    btn_dn = 1'b1;
    tick(3);
    btn_dn = 1'b0;
    tick(8);
    btn_up = 1'b0;
    tick(1);
    check("ign_busy_after_rel", int'(busy), 0);
    tick(4);

    // Up held at q=F: wraps, or limit pulses when saturating.
    q  = 4'hF;
    t0 = cyc;
    expect_step(t0 + 1, 1'b1, q);
    expect_step(t0 + 9, 1'b1, q);
    expect_step(t0 + 13, 1'b1, q);
    btn_up = 1'b1;
    tick(14);
    btn_up = 1'b0;
    tick(5);

    // Short Down press at q=0.
    q  = 4'h0;
    t0 = cyc;
    expect_step(t0 + 1, 1'b0, q);
    btn_dn = 1'b1;
    tick(2);
    btn_dn = 1'b0;
    tick(5);

    // Reset while a repeat strobe is high; no step afterwards until a new rising edge.
    q  = 4'd5;
    t0 = cyc;
    expect_step(t0 + 1, 1'b1, q);
    expect_step(t0 + 9, 1'b1, q);
    btn_up = 1'b1;
    tick(13);
    nrst = 1'b0;
    #1;
    check("rst_mid_cnt_en", int'(cnt_en), 0);
    check("rst_mid_busy", int'(busy), 0);
    btn_up = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(5);
    check("post_rst_busy", int'(busy), 0);
    t0 = cyc;
    expect_step(t0 + 1, 1'b1, q);
    btn_up = 1'b1;
    tick(2);
    btn_up = 1'b0;
    tick(5);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
